// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - store type codes and sequencer state encoding
package store_pkg;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_BYTE = 2'd1;
  localparam logic [1:0] ST_HALF = 2'd2;
  localparam logic [1:0] ST_WORD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/store_merge.sv
// rtl/store_merge.sv - combinational low-lane merge of store data into a read word
module store_merge
  import store_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] reg_b,
  input  logic [1:0]  store_type,
  output logic [31:0] wdata
);

  logic [31:0] mask;

  always_comb begin
    case (store_type)
      ST_BYTE: mask = 32'h0000_00FF;
      ST_HALF: mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  assign wdata = (rdata & ~mask) | (reg_b & mask);

endmodule

// File: rtl/store_sequencer.sv
// rtl/store_sequencer.sv - multicycle sb/sh/sw sequencer on the data-memory port
// Optional alignment check enabled with `define STORE_SEQ_ALIGN_CHECK_EN.
module store_sequencer
  import store_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       reg_b,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       type_q;
  logic [31:0]      data_q;
  logic             bad_req;
  logic             accept;
  logic [1:0]       m_type;
  logic [31:0]      m_data;
  logic [31:0]      merged;

  always_comb begin
    bad_req = (store_type == ST_NONE);
`ifdef STORE_SEQ_ALIGN_CHECK_EN
    if (store_type == ST_HALF && addr[0])
      bad_req = 1'b1;
    if (store_type == ST_WORD && addr[1:0] != 2'b00)
      bad_req = 1'b1;
`endif
  end

  assign accept = (state == S_IDLE) && start;

  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (bad_req)                      next_state = S_DONE;
          else if (store_type == ST_WORD)   next_state = S_WRITE;
          else                              next_state = S_READ;
        end
      end
      S_READ: begin
        next_state = S_WAIT;
        cnt_d      = CNT_W'(MEM_LAT - 1);
      end
      S_WAIT: begin
        if (cnt == '0) next_state = S_WRITE;
        else           cnt_d      = cnt - 1'b1;
      end
      S_WRITE: next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // sw goes straight from IDLE to WRITE, so the merge sees live inputs there
  assign m_type = (state == S_IDLE) ? store_type : type_q;
  assign m_data = (state == S_IDLE) ? reg_b : data_q;

  store_merge u_merge (
    .rdata      (mem_rdata),
    .reg_b      (m_data),
    .store_type (m_type),
    .wdata      (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      type_q    <= ST_NONE;
      data_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_d;
      mem_wr <= (next_state == S_WRITE);
      busy   <= (next_state != S_IDLE);
      done   <= (next_state == S_DONE);
      err    <= (state == S_IDLE) && (next_state == S_DONE);
      if (accept) begin
        type_q <= store_type;
        data_q <= reg_b;
        if (!bad_req)
          mem_addr <= addr;
      end
      if (next_state == S_WRITE)
        mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// tb/tb_store_sequencer.sv - randomized bench for store_sequencer at MEM_LAT 1 and 3
module tb_store_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  store_type = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] reg_b = 32'd0;
  logic        mem_init = 1'b1;

  logic [31:0] rdata1, rdata3, maddr1, maddr3, wdata1, wdata3;
  logic        wr1, wr3, busy1, busy3, done1, done3, err1, err3;

  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] ref_mem [64];
  logic [5:0]  p1, p3a, p3b, p3c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  store_sequencer #(.MEM_LAT(1), .ADDR_W(32)) u_lat1 (
    .clk(clk), .reset(reset), .start(start), .store_type(store_type), .addr(addr),
    .reg_b(reg_b), .mem_rdata(rdata1), .mem_addr(maddr1), .mem_wdata(wdata1),
    .mem_wr(wr1), .busy(busy1), .done(done1), .err(err1)
  );

  store_sequencer #(.MEM_LAT(3), .ADDR_W(32)) u_lat3 (
    .clk(clk), .reset(reset), .start(start), .store_type(store_type), .addr(addr),
    .reg_b(reg_b), .mem_rdata(rdata3), .mem_addr(maddr3), .mem_wdata(wdata3),
    .mem_wr(wr3), .busy(busy3), .done(done3), .err(err3)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'h1122_3344 + 32'(i) * 32'h01F3_A5C7;
  endfunction

  // Word-indexed memories; read data trails the address by exactly the latency
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= init_word(i);
        mem3[i] <= init_word(i);
      end
    end else begin
      if (wr1) mem1[maddr1[7:2]] <= wdata1;
      if (wr3) mem3[maddr3[7:2]] <= wdata3;
    end
    p1  <= maddr1[7:2];
    p3a <= maddr3[7:2];
    p3b <= p3a;
    p3c <= p3b;
  end

  assign rdata1 = mem1[p1];
  assign rdata3 = mem3[p3c];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string who, input int k, input int wr_k, input int dn_k,
                             input logic is_err, input logic [31:0] a, input logic [31:0] wd,
                             input logic busy_o, input logic wr_o, input logic done_o,
                             input logic err_o, input logic [31:0] addr_o,
                             input logic [31:0] wdata_o);
    check({who, "_busy"}, 32'(busy_o), 32'(k <= dn_k));
    check({who, "_wr"},   32'(wr_o),   32'(k == wr_k));
    check({who, "_done"}, 32'(done_o), 32'(k == dn_k));
    check({who, "_err"},  32'(err_o),  32'((k == dn_k) && is_err));
    if (!is_err && k <= dn_k)
      check({who, "_addr"}, addr_o, a);
    if (k == wr_k)
      check({who, "_wdata"}, wdata_o, wd);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_busy", {30'd0, busy1, busy3}, 32'd0);
    check("idle_wr",   {30'd0, wr1, wr3},     32'd0);
  endtask

  task automatic run_txn(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    logic        is_err;
    logic [31:0] mask, exp_wd;
    int          idx, wr_1, wr_3, dn_1, dn_3;
    is_err = (t == 2'd0);
`ifdef STORE_SEQ_ALIGN_CHECK_EN
    if ((t == 2'd2 && a[0]) || (t == 2'd3 && a[1:0] != 2'b00))
      is_err = 1'b1;
`endif
    idx    = int'(a[7:2]);
    mask   = (t == 2'd1) ? 32'h0000_00FF : (t == 2'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    exp_wd = (ref_mem[idx] & ~mask) | (b & mask);
    if (is_err) begin
      wr_1 = -1; wr_3 = -1; dn_1 = 1; dn_3 = 1;
    end else if (t == 2'd3) begin
      wr_1 = 1; wr_3 = 1; dn_1 = 2; dn_3 = 2;
    end else begin
      wr_1 = 3; wr_3 = 5; dn_1 = 4; dn_3 = 6;
    end
    start = 1'b1; store_type = t; addr = a; reg_b = b;
    for (int k = 1; k <= dn_3 + 1; k++) begin
      @(negedge clk);
      check_cycle("l1", k, wr_1, dn_1, is_err, a, exp_wd, busy1, wr1, done1, err1, maddr1, wdata1);
      check_cycle("l3", k, wr_3, dn_3, is_err, a, exp_wd, busy3, wr3, done3, err3, maddr3, wdata3);
      // Junk requests only while both instances are still busy
      if (k <= dn_1) begin
        start      = 1'($urandom_range(0, 1));
        store_type = 2'($urandom);
        addr       = $urandom;
        reg_b      = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!is_err)
      ref_mem[idx] = exp_wd;
  endtask

  task automatic reset_in_write();
    logic [31:0] a, b;
    a = $urandom & 32'hFFFF_FFFC;
    b = $urandom;
    start = 1'b1; store_type = 2'd3; addr = a; reg_b = b;
    @(negedge clk);
    check("rst_pre_wr", {30'd0, wr1, wr3}, 32'd3);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_wr",    {30'd0, wr1, wr3},     32'd0);
    check("rst_busy",  {30'd0, busy1, busy3}, 32'd0);
    check("rst_done",  {30'd0, done1, done3}, 32'd0);
    check("rst_err",   {30'd0, err1, err3},   32'd0);
    check("rst_addr",  maddr1 | maddr3,       32'd0);
    check("rst_wdata", wdata1 | wdata3,       32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_no_done", {30'd0, done1, done3}, 32'd0);
    check("rst_idle",    {30'd0, busy1, busy3}, 32'd0);
    ref_mem[int'(a[7:2])] = b;
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    check("reset_addr",  maddr1 | maddr3, 32'd0);
    check("reset_wdata", wdata1 | wdata3, 32'd0);
    check("reset_flags", {26'd0, wr1, wr3, busy1, busy3, done1 | err1, done3 | err3}, 32'd0);
    reset = 1'b0;
    idle_cycle();

    run_txn(2'd3, 32'h0000_0040, 32'hDEAD_BEEF);
    run_txn(2'd1, 32'h0000_0000, 32'hAABB_CCDD);
    run_txn(2'd2, 32'h0000_0000, 32'hAABB_CCDD);
    check("tp_sh_word", ref_mem[0], 32'h1122_CCDD);
    run_txn(2'd0, 32'h0000_0010, 32'h0000_1234);
    run_txn(2'd3, 32'h0000_0042, 32'hCAFE_F00D);
    run_txn(2'd2, 32'h0000_0081, 32'h1357_9BDF);
    run_txn(2'd1, 32'h0000_0083, 32'h0000_00A5);
    reset_in_write();
    idle_cycle();

    for (int n = 0; n < 80; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++)
        idle_cycle();
      run_txn(2'($urandom), $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_sequencer.md
Name: store_sequencer

Overview:
Multicycle controller that executes sb/sh/sw as memory transactions on the shared data-memory port.
- sw: single write.
- sb/sh: read-modify-write. Reads the addressed word, merges the low byte or halfword of reg_b into the low lane, writes the result back.
- Sits between the main control FSM, which issues one store request at a time, and the synchronous data memory.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (>=1). Read data is valid MEM_LAT cycles after the address is presented.
- ADDR_W, 32, address width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  store request, sampled in IDLE only
- store_type  input  2  0=invalid, 1=byte, 2=half, 3=word
- addr  input  ADDR_W  store address
- reg_b  input  32  store source data
- mem_rdata  input  32  memory read data
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  32  memory write data
- mem_wr  output  1  memory write strobe
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse, coincident with done

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered. On reset they are: mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, err=0; state=IDLE.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - start=1 latches addr, reg_b and store_type.
  - type 3 -> WRITE; type 1/2 -> READ; type 0 -> DONE with err set.
- READ (1 cycle): mem_addr=addr, mem_wr=0. Next state WAIT; latency counter loaded with MEM_LAT-1.
- WAIT (MEM_LAT cycles):
  - Counter decrements each cycle.
  - When the counter is 0, mem_rdata is captured into the merge register and the next state is WRITE.
- WRITE (1 cycle): mem_wr=1, mem_addr=addr, mem_wdata as follows:
  - byte: {rdata[31:8], reg_b[7:0]}
  - half: {rdata[31:16], reg_b[15:0]}
  - word: reg_b
- DONE (1 cycle): done=1; err=1 only on the error path. Next state IDLE.
- Timing, start sampled at edge t, MEM_LAT=1:
  - sb/sh: READ t+1, WAIT t+2, WRITE t+3, DONE t+4, IDLE t+5.
  - sw: WRITE t+1, DONE t+2.
  - type 0: DONE t+1.
- mem_addr is held stable from READ/WRITE entry through DONE.
- mem_wr is asserted in WRITE only, for exactly one cycle per transaction. mem_wr=0 on every other cycle.
- start while busy=1 is ignored: no queueing, and latched operands stay unchanged. Input changes mid-transaction have no effect.
- A new start is accepted in the IDLE cycle directly after DONE, so back-to-back issue costs no extra bubble.
- Reset mid-operation: after the edge, state=IDLE and all outputs are at reset values, including mem_wr=0 even if reset hits in WRITE. No done pulse is generated for the aborted transaction.
- Merge is always into the low lane; addr[1:0] does not select the lane.

Optional Feature:
- Macro: STORE_SEQ_ALIGN_CHECK_EN.
- Defined:
  - sh with addr[0]!=0 goes IDLE -> DONE with err=1.
  - sw with addr[1:0]!=0 goes IDLE -> DONE with err=1.
  - Neither case performs a memory access or asserts mem_wr. sb is never misaligned.
- Undefined: no alignment check; the address is used as given and err fires only for store_type 0.

Decomposition:
- Package store_pkg: constants ST_NONE=0, ST_BYTE=1, ST_HALF=2, ST_WORD=3; FSM state encoding (3-bit) for IDLE/READ/WAIT/WRITE/DONE.
- Sub-module store_merge: combinational lane merge (rdata, reg_b, store_type -> wdata), instantiated once by store_sequencer.

Test Plan:
- sw, addr=0x40, reg_b=0xDEADBEEF -> mem_wr=1 at t+1 with mem_wdata=0xDEADBEEF and mem_addr=0x40; done at t+2; no READ cycle.
- sb, memory word 0x11223344, reg_b=0xAABBCCDD, MEM_LAT=1 -> mem_wr at t+3 with 0x112233DD; done at t+4.
- sh on the same word with MEM_LAT=3 -> WRITE at t+5 with 0x1122CCDD; done at t+6.
- store_type=0 -> done=1 and err=1 at t+1; mem_wr never asserted.
- start pulsed during WAIT with different operands -> ignored; original transaction completes unchanged. Separately, reset asserted in WRITE -> mem_wr=0, busy=0 next cycle, no done.
- With STORE_SEQ_ALIGN_CHECK_EN: sw at addr 0x42 -> err=1 at t+1, no mem_wr. Without the macro, the same request writes at 0x42.
